// File: rtl/pc_update_unit.sv
// Program counter register with next-PC selection, memory-stall hold,
// redirect capture across stalls and a sticky stall watchdog.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_INIT    | first cycle after reset, PC parked at RESET_VECTOR, not valid
//   S_RUN     | normal fetch, PC advances or redirects every cycle
//   S_STALL   | memory busy, PC held, first resolved redirect is captured
//   S_TIMEOUT | stall ran too long, PC frozen and invalid until reset
module pc_update_unit #(
  parameter int                 PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                 STALL_LIMIT  = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [PC_WIDTH-1:0] PC4,
  input  logic [PC_WIDTH-1:0] OFFSET,
  input  logic                JUMP,
  input  logic                BRANCH_EQ,
  input  logic                BRANCH_NE,
  input  logic                ZERO,
  input  logic                BUSYWAIT,
  output logic [PC_WIDTH-1:0] PC,
  output logic                PC_VALID,
  output logic                FLUSH,
  output logic                STALL_TIMEOUT
);

  localparam int             CNT_W = 16;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL, S_TIMEOUT} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt;
  logic [PC_WIDTH-1:0] pend_t, pend_t_nxt;
  logic                pend_v, pend_v_nxt;
  logic                flush_q, flush_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic                taken;
  logic [PC_WIDTH-1:0] target;

  // Branch priority: JUMP, then BEQ, then BNE; with BEQ and BNE both set only BEQ counts.
  always_comb begin
    taken = 1'b0;
    if (JUMP)
      taken = 1'b1;
    else if (BRANCH_EQ)
      taken = ZERO;
    else if (BRANCH_NE)
      taken = ~ZERO;
  end

  assign target  = PC4 + OFFSET;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= S_INIT;
    else
      state <= state_nxt;
  end

  // The counter is always zero in S_RUN, so cnt_inc is the stalled-cycle count there too.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:    state_nxt = S_RUN;
      S_RUN,
      S_STALL: begin
        if (BUSYWAIT)
          state_nxt = (cnt_inc >= LIMIT) ? S_TIMEOUT : S_STALL;
        else
          state_nxt = S_RUN;
      end
      S_TIMEOUT: state_nxt = S_TIMEOUT;
      default:   state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    pc_nxt     = pc_q;
    flush_nxt  = 1'b0;
    pend_v_nxt = pend_v;
    pend_t_nxt = pend_t;
    cnt_nxt    = cnt;
    case (state)
      S_RUN: begin
        if (BUSYWAIT) begin
          cnt_nxt = cnt_inc;
          if (taken) begin
            pend_v_nxt = 1'b1;
            pend_t_nxt = target;
          end
        end else begin
          pc_nxt    = taken ? target : PC4;
          flush_nxt = taken;
          cnt_nxt   = '0;
        end
      end
      S_STALL: begin
        if (BUSYWAIT) begin
          cnt_nxt = cnt_inc;
          if (taken && !pend_v) begin
            pend_v_nxt = 1'b1;
            pend_t_nxt = target;
          end
        end else begin
          pc_nxt     = pend_v ? pend_t : (taken ? target : PC4);
          flush_nxt  = pend_v | taken;
          pend_v_nxt = 1'b0;
          cnt_nxt    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
      pend_v  <= 1'b0;
      pend_t  <= '0;
      cnt     <= '0;
    end else begin
      pc_q    <= pc_nxt;
      flush_q <= flush_nxt;
      pend_v  <= pend_v_nxt;
      pend_t  <= pend_t_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    PC            = pc_q;
    FLUSH         = flush_q;
    PC_VALID      = (state == S_RUN) || (state == S_STALL);
    STALL_TIMEOUT = (state == S_TIMEOUT);
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: vector table for single-cycle redirects,
// hand sequences for stalls, reset-mid-stall and the watchdog (STALL_LIMIT=4).
module tb_pc_update_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC4, OFFSET;
  logic        JUMP, BRANCH_EQ, BRANCH_NE, ZERO, BUSYWAIT;
  logic [31:0] PC;
  logic        PC_VALID, FLUSH, STALL_TIMEOUT;

  int n_checks = 0;
  int n_fail   = 0;

  pc_update_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .STALL_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET), .PC4(PC4), .OFFSET(OFFSET), .JUMP(JUMP),
    .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .BUSYWAIT(BUSYWAIT),
    .PC(PC), .PC_VALID(PC_VALID), .FLUSH(FLUSH), .STALL_TIMEOUT(STALL_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] pc4;
    logic [31:0] offset;
    logic        jump, beq, bne, zero;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc4, input logic [31:0] off, input logic j,
                       input logic beq, input logic bne, input logic z, input logic busy);
    PC4 = pc4; OFFSET = off; JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne;
    ZERO = z; BUSYWAIT = busy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic valid,
                           input logic flush, input logic tmo);
    chk({name, ".pc"}, PC, pc);
    chk({name, ".valid"}, {31'b0, PC_VALID}, {31'b0, valid});
    chk({name, ".flush"}, {31'b0, FLUSH}, {31'b0, flush});
    chk({name, ".timeout"}, {31'b0, STALL_TIMEOUT}, {31'b0, tmo});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] exp_pc;

    vecs[0] = '{"beq_taken",   32'h24, 32'h10,       1'b0, 1'b1, 1'b0, 1'b1, 32'h34,       1'b1};
    vecs[1] = '{"beq_not",     32'h24, 32'h10,       1'b0, 1'b1, 1'b0, 1'b0, 32'h24,       1'b0};
    vecs[2] = '{"bne_wrap",    32'h0C, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b1};
    vecs[3] = '{"jump_wrap0",  32'h40, 32'hFFFFFFC0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
    vecs[4] = '{"beq_over_bne",32'h50, 32'h100,      1'b0, 1'b1, 1'b1, 1'b0, 32'h50,       1'b0};
    vecs[5] = '{"bne_not",     32'h60, 32'h10,       1'b0, 1'b0, 1'b1, 1'b1, 32'h60,       1'b0};
    vecs[6] = '{"jump_prio",   32'h70, 32'h10,       1'b1, 1'b1, 1'b0, 1'b0, 32'h80,       1'b1};
    vecs[7] = '{"seq",         32'h84, 32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h84,       1'b0};

    // Reset and power-up sequence
    RESET = 1'b1;
    drive(32'h4, 32'h0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_state("reset", 32'h0, 0, 0, 0);
    RESET = 1'b0;
    chk_state("init", 32'h0, 0, 0, 0);
    tick();
    chk_state("run0", 32'h0, 1, 0, 0);
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      drive(exp_pc + 32'h4, 32'h0, 0, 0, 0, 0, 0);
      tick();
      exp_pc = exp_pc + 32'h4;
      chk_state("seq_inc", exp_pc, 1, 0, 0);
    end

    // Single-cycle redirect table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].pc4, vecs[i].offset, vecs[i].jump, vecs[i].beq, vecs[i].bne, vecs[i].zero, 1'b0);
      tick();
      chk_state(vecs[i].name, vecs[i].exp_pc, 1, vecs[i].exp_flush, 0);
    end

    // Stall with a redirect in cycle 1; later redirects ignored; pending beats a same-cycle branch
    drive(32'h88, 32'h78, 1, 0, 0, 0, 1);
    tick();
    chk_state("stall1", 32'h84, 1, 0, 0);
    drive(32'h88, 32'h200, 1, 0, 0, 0, 1);
    tick();
    chk_state("stall2", 32'h84, 1, 0, 0);
    drive(32'h88, 32'h0, 0, 0, 0, 0, 1);
    tick();
    chk_state("stall3", 32'h84, 1, 0, 0);
    drive(32'h88, 32'h300, 0, 1, 0, 1, 0);
    tick();
    chk_state("stall_release", 32'h100, 1, 1, 0);
    drive(32'h104, 32'h0, 0, 0, 0, 0, 0);
    tick();
    chk_state("after_release", 32'h104, 1, 0, 0);

    // Stall without pending, redirect resolves on release
    drive(32'h108, 32'h0, 0, 0, 0, 0, 1);
    tick();
    chk_state("stall_nopend", 32'h104, 1, 0, 0);
    drive(32'h108, 32'h8, 0, 0, 1, 0, 0);
    tick();
    chk_state("release_taken", 32'h110, 1, 1, 0);

    // Reset while a redirect is pending
    drive(32'h114, 32'h1000, 1, 0, 0, 0, 1);
    tick();
    chk_state("pend_before_rst", 32'h110, 1, 0, 0);
    RESET = 1'b1;
    tick();
    chk_state("rst_mid_stall", 32'h0, 0, 0, 0);
    RESET = 1'b0;
    drive(32'h4, 32'h0, 0, 0, 0, 0, 0);
    chk_state("rst_init", 32'h0, 0, 0, 0);
    tick();
    chk_state("rst_run0", 32'h0, 1, 0, 0);
    tick();
    chk_state("rst_run4", 32'h4, 1, 0, 0);
    drive(32'h8, 32'h0, 0, 0, 0, 0, 0);
    tick();
    chk_state("rst_run8", 32'h8, 1, 0, 0);

    // Watchdog: four stalled cycles with STALL_LIMIT=4
    drive(32'hC, 32'h40, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_state("wd_stall", 32'h8, 1, 0, 0);
    end
    tick();
    chk_state("wd_timeout", 32'h8, 0, 0, 1);
    drive(32'hC, 32'h40, 1, 0, 0, 0, 0);
    tick();
    chk_state("wd_sticky1", 32'h8, 0, 0, 1);
    tick();
    chk_state("wd_sticky2", 32'h8, 0, 0, 1);
    RESET = 1'b1;
    tick();
    chk_state("wd_reset", 32'h0, 0, 0, 0);
    RESET = 1'b0;
    drive(32'h4, 32'h0, 0, 0, 0, 0, 0);
    tick();
    chk_state("wd_run0", 32'h0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter register and next-PC selection stage. Sits directly downstream of the PC+4 adder and the branch/jump offset adder.
- Consumes PC4 and OFFSET, resolves J/BEQ/BNE against the ALU ZERO flag, and registers the next PC.
- Holds the PC while instruction/data memory asserts BUSYWAIT. Remembers a redirect that resolves during a stall.
- Flags a runaway stall with a watchdog.

Parameters:
- PC_WIDTH, 32: width of PC, PC4, OFFSET.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- STALL_LIMIT, 255: consecutive stalled cycles before timeout. Legal range 1..65535.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- PC4  input  PC_WIDTH  current PC+4 from the increment adder.
- OFFSET  input  PC_WIDTH  sign-extended byte offset (imm<<2) from the offset adder.
- JUMP  input  1  unconditional jump decoded.
- BRANCH_EQ  input  1  BEQ decoded.
- BRANCH_NE  input  1  BNE decoded.
- ZERO  input  1  ALU zero flag for the current instruction.
- BUSYWAIT  input  1  memory stall request. While high, the PC must not advance.
- PC  output  PC_WIDTH  registered program counter.
- PC_VALID  output  1  PC is a fetchable address.
- FLUSH  output  1  one-cycle pulse after a redirect is applied.
- STALL_TIMEOUT  output  1  sticky watchdog flag.

Behaviour:
- Clock and reset:
  - Single clock. All state updates on the CLK rising edge. No internal delays.
  - RESET is synchronous and active-high. It wins over every other input.
  - On reset: PC=RESET_VECTOR, PC_VALID=0, FLUSH=0, STALL_TIMEOUT=0, pending redirect cleared, stall counter=0, state=INIT.
- Redirect decision and target (combinational each cycle):
  - taken = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO).
  - Priority: JUMP > BRANCH_EQ > BRANCH_NE. With BRANCH_EQ and BRANCH_NE both high, only BRANCH_EQ is evaluated.
  - target = PC4 + OFFSET, modulo 2^PC_WIDTH. Wrap-around is silent; a negative OFFSET below address 0 wraps.
- State machine:
  - INIT: one cycle, PC held at RESET_VECTOR. Next state is RUN with PC_VALID=1. Controls are ignored in INIT.
  - RUN, BUSYWAIT=0: PC<=taken?target:PC4. FLUSH<=taken. Counter=0.
  - RUN, BUSYWAIT=1: PC held, FLUSH<=0, go to STALL, counter<=1. If taken, latch pending_target=target and set pending_valid.
  - STALL, BUSYWAIT=1:
    - PC held, counter increments.
    - If taken and pending_valid=0, latch the target. The first resolved redirect wins; later changes are ignored.
    - When the counter reaches STALL_LIMIT: go to TIMEOUT.
  - STALL, BUSYWAIT=0:
    - PC<=pending_valid ? pending_target : (taken ? target : PC4).
    - FLUSH<=pending_valid|taken.
    - Clear pending_valid, counter=0, return to RUN.
  - TIMEOUT: PC_VALID=0, STALL_TIMEOUT=1, PC frozen, FLUSH=0, all inputs ignored. Exited only by RESET.
- Boundary conditions:
  - BUSYWAIT falling and a new taken decision in the same cycle: the latched pending target has priority.
  - The stall counter saturates; it never wraps.
  - RESET mid-stall or mid-timeout discards any pending redirect. The next cycle behaves as if after power-up.
  - Latency: one cycle from input to PC. FLUSH is asserted in the same cycle as the new PC.

Test Plan:
- RESET high for 2 cycles, then low, BUSYWAIT=0, no controls -> PC=0 with PC_VALID=0 for one cycle. Then PC=0 with PC_VALID=1, then 4, 8, 12. FLUSH stays 0.
- PC=0x20, PC4=0x24, OFFSET=0x10, BRANCH_EQ=1, ZERO=1 -> next PC=0x34, FLUSH=1 for one cycle. Same stimulus with ZERO=0 -> PC=0x24, FLUSH=0.
- PC=0x08, PC4=0x0C, OFFSET=0xFFFFFFF0, BRANCH_NE=1, ZERO=0 -> PC=0xFFFFFFFC (wrap). JUMP=1, PC4=0x40, OFFSET=0xFFFFFFC0 -> PC=0x0.
- BUSYWAIT=1 for 3 cycles with JUMP=1 and target=0x100 in cycle 1, then controls cleared -> PC held for 3 cycles, then PC=0x100 with FLUSH=1.
- STALL_LIMIT=4, BUSYWAIT held high -> after 4 stalled cycles STALL_TIMEOUT=1, PC_VALID=0. Dropping BUSYWAIT changes nothing. RESET clears both flags and restores PC=RESET_VECTOR.
- RESET asserted during a stall with a latched redirect pending -> PC=RESET_VECTOR. After release, the sequence continues 0, 4, 8 with no FLUSH.
